grph_blitter: RTL and testbench
===============================

# grph_blitter

Fill/copy engine for the 128 KB graphics video memory, sharing that memory's CPU-side port with the CPU. It sits between the memory controller and port A of the graphics video RAM. The memory controller issues commands; the blitter then writes (or reads and writes) the RAM while the CPU keeps strict priority on every cycle. The VGA side (port B) is untouched.

## Interface
- ADDR_W, 17: byte address width of the graphics video memory.
- clock  in  1  system clock (same clock as the RAM port).
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when IDLE. A command is accepted on `cmd_valid & cmd_ready`.
- cmd_op  in  1  0 = FILL, 1 = COPY.
- cmd_src  in  ADDR_W  copy source start address.
- cmd_dst  in  ADDR_W  destination start address.
- cmd_len  in  ADDR_W  byte count. 0 means no memory access.
- cmd_fill  in  8  fill byte.
- cpu_req  in  1  the CPU uses the RAM port this cycle.
- cpu_addr  in  ADDR_W; cpu_wren  in  1; cpu_data  in  8  CPU access.
- mem_addr  out  ADDR_W; mem_data  out  8; mem_wren  out  1  to RAM port A.
- mem_q  in  8  RAM read data, valid one cycle after the address.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- **Port mux (combinational)**
  - When `cpu_req=1`, `mem_*` carry the `cpu_*` signals, with `mem_wren = cpu_wren`.
  - Otherwise `mem_*` carry the blitter's request. If the blitter has no request, `mem_wren=0`.
- **A blitter request is granted only when `cpu_req=0`.** An ungranted request is held unchanged and retried the next cycle.
- **States:** IDLE, FILL, RD, CAP, WR, FIN.
- **IDLE**
  - On accept, latch `src`, `dst`, `len` and `fill`.
  - If `len=0`, go to FIN.
  - Else if FILL, go to FILL; if COPY, go to RD.
- **FILL**
  - Request a write of `fill` to `dst`.
  - On grant: `dst+=1`, `len-=1`. When `len` reaches 0, go to FIN.
- **RD:** request a read of `src`. On grant: `src+=1`, go to CAP.
- **CAP:** unconditionally latch `mem_q` into `hold`, then go to WR. The RAM output reflects the granted read address even if the CPU owns the port in CAP.
- **WR**
  - Request a write of `hold` to `dst`.
  - On grant: `dst+=1`, `len-=1`. Then go to FIN if `len` is 0, else back to RD.
- **FIN:** `done=1` for this cycle, then go to IDLE.
- **Address arithmetic:** modulo 2^ADDR_W; `0x1FFFF+1` wraps to `0`.
- **Overlap:** copies always run ascending. No overlap correction is made, so a forward overlap (`dst>src`) smears data; this is intended.
- **New commands:** `cmd_valid` while busy is ignored (`cmd_ready=0`). There is no queueing.

## Timing
- **Reset (asynchronous)**
  - State goes to IDLE, registers clear, `busy=0`, `done=0`, `cmd_ready=1`.
  - `mem_*` mirror `cpu_*` (or 0 when `cpu_req=0`).
- **Reset mid-command:** the command is aborted immediately. Bytes already written remain; no `done` pulse.
- **Accept** at edge k: `busy=1` and `cmd_ready=0` from k.
- **FILL, no contention:** writes in cycles k..k+N-1, FIN in cycle k+N (`done=1`, `busy=1`), IDLE and `cmd_ready=1` at k+N+1.
- **COPY, no contention:** 3 cycles per byte (RD, CAP, WR). `done` in cycle k+3N.
- **Zero-length command:** `done` in cycle k, no `mem_wren`.
- **Stalls:** each cycle with `cpu_req=1` during a FILL/RD/WR request adds exactly one cycle. Stalls during CAP add nothing.

## Configuration
- **`GRPH_BLITTER_COPY_EN` defined:** COPY supported as above.
- **Undefined:**
  - RD, CAP and `hold` are not built.
  - `cmd_op=1` is accepted and treated as `len=0`: FIN, `done` pulse, no RAM access.
  - `cmd_src` is ignored.

## Structure
- Package `grph_blitter_pkg`:
  - ADDR_W.
  - Op encoding (OP_FILL=0, OP_COPY=1).
  - State enum.
- Single module. The port mux is inline; no sub-module is warranted.

## Test plan
- **Reset:** reset mid-FILL (dst=0x100, len=16) after 5 writes → `busy=0`, `cmd_ready=1`, no `done`; exactly bytes 0x100–0x104 written.
- **FILL basic:** FILL dst=0x1FFFE, len=4, fill=0xA5, `cpu_req=0` → writes 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 with 0xA5 in 4 consecutive cycles; `done` one cycle later.
- **COPY basic:** COPY src=0x00010, dst=0x00100, len=3, RAM preloaded 11,22,33 → 0x100..0x102 = 11,22,33; `done` at accept+9.
- **CPU contention:** FILL len=8 with `cpu_req` toggling every cycle and the CPU writing 0x5A to 0x08000 → all 8 fill bytes written, CPU write lands, `done` at accept+16. CPU held high during CAP → copied byte still correct.
- **Zero length / busy:** len=0 → `done` at accept cycle, no `mem_wren`; `cmd_valid` during busy ignored.
- **Macro off:** COPY command → `done` pulse, no RAM access.

Source files
------------

// File: rtl/grph_blitter_pkg.sv
// Shared definitions for the graphics-memory fill/copy blitter.
package grph_blitter_pkg;

  localparam int ADDR_W = 17;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_COPY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_FIN
  } blt_state_e;

endpackage

// File: rtl/grph_blitter.sv
// Fill/copy engine sharing video-RAM port A with the CPU; the CPU always wins the port.
// COPY support is built only when GRPH_BLITTER_COPY_EN is defined.
module grph_blitter
  import grph_blitter_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [7:0]        cmd_fill,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wren,
  input  logic [7:0]        cpu_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wren,
  input  logic [7:0]        mem_q,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  blt_state_e        r_state;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_len;
  logic [7:0]        r_fill;
`ifdef GRPH_BLITTER_COPY_EN
  logic [ADDR_W-1:0] r_src;
  logic [7:0]        r_hold;
`else
  logic              w_unused;
  assign w_unused = ^{cmd_src, mem_q};
`endif

  logic              w_req;
  logic              w_wren;
  logic              w_grant;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;

  // Blitter request; address/data are zero when nothing is requested.
  always_comb begin
    w_req  = 1'b0;
    w_wren = 1'b0;
    w_addr = '0;
    w_data = '0;
    case (r_state)
      ST_FILL: begin
        w_req  = 1'b1;
        w_wren = 1'b1;
        w_addr = r_dst;
        w_data = r_fill;
      end
`ifdef GRPH_BLITTER_COPY_EN
      ST_RD: begin
        w_req  = 1'b1;
        w_addr = r_src;
      end
      ST_WR: begin
        w_req  = 1'b1;
        w_wren = 1'b1;
        w_addr = r_dst;
        w_data = r_hold;
      end
`endif
      default: ;
    endcase
  end

  assign w_grant  = w_req & ~cpu_req;

  assign mem_addr = cpu_req ? cpu_addr : w_addr;
  assign mem_data = cpu_req ? cpu_data : w_data;
  assign mem_wren = cpu_req ? cpu_wren : w_wren;

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FIN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_dst   <= '0;
      r_len   <= '0;
      r_fill  <= '0;
`ifdef GRPH_BLITTER_COPY_EN
      r_src   <= '0;
      r_hold  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_dst  <= cmd_dst;
            r_len  <= cmd_len;
            r_fill <= cmd_fill;
`ifdef GRPH_BLITTER_COPY_EN
            r_src  <= cmd_src;
`endif
            if (cmd_len == '0) begin
              r_state <= ST_FIN;
            end else begin
              case (cmd_op)
                OP_FILL: r_state <= ST_FILL;
`ifdef GRPH_BLITTER_COPY_EN
                OP_COPY: r_state <= ST_RD;
`else
                OP_COPY: r_state <= ST_FIN;
`endif
                default: r_state <= ST_FIN;
              endcase
            end
          end
        end
        ST_FILL: begin
          if (w_grant) begin
            r_dst <= r_dst + ONE;
            r_len <= r_len - ONE;
            if (r_len == ONE) r_state <= ST_FIN;
          end
        end
`ifdef GRPH_BLITTER_COPY_EN
        ST_RD: begin
          if (w_grant) begin
            r_src   <= r_src + ONE;
            r_state <= ST_CAP;
          end
        end
        // RAM output reflects the read granted last cycle, whoever owns the port now.
        ST_CAP: begin
          r_hold  <= mem_q;
          r_state <= ST_WR;
        end
        ST_WR: begin
          if (w_grant) begin
            r_dst   <= r_dst + ONE;
            r_len   <= r_len - ONE;
            r_state <= (r_len == ONE) ? ST_FIN : ST_RD;
          end
        end
`endif
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grph_blitter.sv
// Directed self-checking bench for grph_blitter with a behavioural synchronous RAM on port A.
module tb_grph_blitter;
  import grph_blitter_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              cmd_valid, cmd_ready, cmd_op;
  logic [ADDR_W-1:0] cmd_src, cmd_dst, cmd_len;
  logic [7:0]        cmd_fill;
  logic              cpu_req, cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data, mem_q;
  logic              mem_wren, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] log_addr[$];
  logic [7:0]        log_data[$];
  int                log_cyc[$];

  grph_blitter dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren), .cpu_data(cpu_data),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mem_wren) begin
      ram[mem_addr] <= mem_data;
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_data);
      log_cyc.push_back(cyc);
    end
    mem_q <= ram[mem_addr];
  end

  task automatic run_cmd(input logic op, input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                         input logic [ADDR_W-1:0] len, input logic [7:0] fv, input int budget,
                         output int k, output int dcyc, output logic dbusy);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_fill = fv;
    @(posedge clock); #1;
    k = cyc;
    cmd_valid = 1'b0;
    dcyc = -1;
    dbusy = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin
        dcyc = cyc;
        dbusy = busy;
        break;
      end
    end
  endtask

  task automatic cpu_poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clock);
    cpu_req = 1'b1; cpu_addr = a; cpu_wren = 1'b1; cpu_data = d;
    @(negedge clock);
    cpu_req = 1'b0; cpu_wren = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_wren = 1'b0; cpu_data = '0;
    cmd_valid = 1'b0; cmd_op = OP_FILL; cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_fill = '0;
    #12;
    n_checks++;
    if ({busy, done, cmd_ready, mem_wren} !== 4'b0010) begin
      n_fail++; $display("FAIL reset_flags: got busy/done/ready/wren=%b want 0010", {busy, done, cmd_ready, mem_wren});
    end
    n_checks++;
    if ({mem_addr, mem_data} !== '0) begin
      n_fail++; $display("FAIL reset_idle_port: got addr=%h data=%h want 0/0", mem_addr, mem_data);
    end
    cpu_req = 1'b1; cpu_addr = 17'h0F0F0; cpu_wren = 1'b1; cpu_data = 8'hC3;
    #1;
    n_checks++;
    if ({mem_addr, mem_data, mem_wren} !== {17'h0F0F0, 8'hC3, 1'b1}) begin
      n_fail++; $display("FAIL reset_cpu_mux: got addr=%h data=%h wren=%b want 0f0f0/c3/1", mem_addr, mem_data, mem_wren);
    end
    cpu_req = 1'b0; cpu_wren = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_fill;
    int idx0, k, d0, n;
    idx0 = log_addr.size();
    d0 = done_cnt;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_dst = 17'h00100; cmd_len = 17'd16; cmd_fill = 8'hE7;
    @(posedge clock); #1;
    k = cyc;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, cmd_ready, done, mem_wren} !== 4'b0100) begin
      n_fail++; $display("FAIL midreset_flags: got busy/ready/done/wren=%b want 0100", {busy, cmd_ready, done, mem_wren});
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    n = log_addr.size() - idx0;
    n_checks++;
    if (n !== 5) begin
      n_fail++; $display("FAIL midreset_count: got %0d writes want 5", n);
    end
    for (int i = 0; i < n && i < 5; i++) begin
      n_checks++;
      if (log_addr[idx0+i] !== 17'(17'h00100 + i) || log_data[idx0+i] !== 8'hE7) begin
        n_fail++; $display("FAIL midreset_write%0d: got %h=%h want %h=e7", i, log_addr[idx0+i], log_data[idx0+i], 17'(17'h00100 + i));
      end
    end
    n_checks++;
    if (done_cnt !== d0) begin
      n_fail++; $display("FAIL midreset_nodone: got %0d done pulses want 0", done_cnt - d0);
    end
  endtask

  task automatic test_fill_basic;
    int idx0, k, d, n;
    logic db;
    idx0 = log_addr.size();
    run_cmd(OP_FILL, '0, 17'h1FFFE, 17'd4, 8'hA5, 40, k, d, db);
    n = log_addr.size() - idx0;
    n_checks++;
    if (n !== 4) begin
      n_fail++; $display("FAIL fill_count: got %0d writes want 4", n);
    end
    for (int i = 0; i < n && i < 4; i++) begin
      n_checks++;
      if (log_addr[idx0+i] !== 17'(17'h1FFFE + i) || log_data[idx0+i] !== 8'hA5 || log_cyc[idx0+i] !== k + i) begin
        n_fail++; $display("FAIL fill_write%0d: got %h=%h @%0d want %h=a5 @%0d", i,
                           log_addr[idx0+i], log_data[idx0+i], log_cyc[idx0+i] - k, 17'(17'h1FFFE + i), i);
      end
    end
    n_checks++;
    if (d !== k + 4 || db !== 1'b1) begin
      n_fail++; $display("FAIL fill_done: got cycle %0d busy %b want cycle 4 busy 1", d - k, db);
    end
    @(negedge clock);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL fill_idle: got ready=%b busy=%b want 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_contention;
    int idx0, k, d, nf;
    logic db;
    idx0 = log_addr.size();
    fork
      run_cmd(OP_FILL, '0, 17'h00200, 17'd8, 8'h3C, 60, k, d, db);
      begin
        @(negedge clock);
        @(posedge clock); #1;
        for (int j = 0; j < 16; j++) begin
          cpu_req = (j % 2 == 0); cpu_addr = 17'h08000; cpu_wren = 1'b1; cpu_data = 8'h5A;
          @(posedge clock); #1;
        end
        cpu_req = 1'b0; cpu_wren = 1'b0;
      end
    join
    n_checks++;
    if (d !== k + 16) begin
      n_fail++; $display("FAIL contention_done: got cycle %0d want 16", d - k);
    end
    nf = 0;
    for (int i = idx0; i < log_addr.size(); i++) begin
      if (log_addr[i] != 17'h08000) begin
        n_checks++;
        if (log_addr[i] !== 17'(17'h00200 + nf) || log_cyc[i] !== k + 1 + 2 * nf) begin
          n_fail++; $display("FAIL contention_write%0d: got %h @%0d want %h @%0d", nf, log_addr[i],
                             log_cyc[i] - k, 17'(17'h00200 + nf), 1 + 2 * nf);
        end
        nf++;
      end
    end
    n_checks++;
    if (nf !== 8) begin
      n_fail++; $display("FAIL contention_count: got %0d fill writes want 8", nf);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (ram[17'h00200 + i] !== 8'h3C) begin
        n_fail++; $display("FAIL contention_ram%0d: got %h want 3c", i, ram[17'h00200 + i]);
      end
    end
    n_checks++;
    if (ram[17'h08000] !== 8'h5A) begin
      n_fail++; $display("FAIL contention_cpu: got %h want 5a", ram[17'h08000]);
    end
  endtask

  task automatic test_zero_busy;
    int idx0, k, d, n;
    logic db;
    idx0 = log_addr.size();
    run_cmd(OP_FILL, '0, 17'h00400, 17'd0, 8'h66, 10, k, d, db);
    n_checks++;
    if (d !== k || db !== 1'b1) begin
      n_fail++; $display("FAIL zero_done: got cycle %0d busy %b want cycle 0 busy 1", d - k, db);
    end
    @(negedge clock);
    n_checks++;
    if (log_addr.size() !== idx0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_nowrite: got %0d writes ready=%b want 0 writes ready=1", log_addr.size() - idx0, cmd_ready);
    end
    idx0 = log_addr.size();
    cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_dst = 17'h00500; cmd_len = 17'd4; cmd_fill = 8'h11;
    @(posedge clock); #1;
    k = cyc;
    cmd_dst = 17'h00600; cmd_len = 17'd2; cmd_fill = 8'h22;
    @(negedge clock);
    n_checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_ready: got ready=%b busy=%b want 0/1", cmd_ready, busy);
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    d = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done) begin d = cyc; break; end
    end
    n_checks++;
    if (d !== k + 4) begin
      n_fail++; $display("FAIL busy_done: got cycle %0d want 4", d - k);
    end
    repeat (5) @(negedge clock);
    n = log_addr.size() - idx0;
    n_checks++;
    if (n !== 4) begin
      n_fail++; $display("FAIL busy_count: got %0d writes want 4", n);
    end
    for (int i = 0; i < n && i < 4; i++) begin
      n_checks++;
      if (log_addr[idx0+i] !== 17'(17'h00500 + i) || log_data[idx0+i] !== 8'h11) begin
        n_fail++; $display("FAIL busy_write%0d: got %h=%h want %h=11", i, log_addr[idx0+i], log_data[idx0+i], 17'(17'h00500 + i));
      end
    end
  endtask

`ifdef GRPH_BLITTER_COPY_EN
  task automatic test_copy_basic;
    int idx0, k, d, n;
    logic db;
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    for (int i = 0; i < 3; i++) cpu_poke(17'(17'h00010 + i), exp[i]);
    idx0 = log_addr.size();
    run_cmd(OP_COPY, 17'h00010, 17'h00100, 17'd3, 8'h00, 60, k, d, db);
    n_checks++;
    if (d !== k + 9) begin
      n_fail++; $display("FAIL copy_done: got cycle %0d want 9", d - k);
    end
    n = log_addr.size() - idx0;
    n_checks++;
    if (n !== 3) begin
      n_fail++; $display("FAIL copy_count: got %0d writes want 3", n);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ram[17'h00100 + i] !== exp[i]) begin
        n_fail++; $display("FAIL copy_ram%0d: got %h want %h", i, ram[17'h00100 + i], exp[i]);
      end
    end
  endtask

  task automatic test_cap_stall;
    int k, d;
    logic db;
    cpu_poke(17'h00020, 8'h77);
    cpu_poke(17'h00040, 8'h99);
    fork
      run_cmd(OP_COPY, 17'h00020, 17'h00300, 17'd1, 8'h00, 30, k, d, db);
      begin
        @(negedge clock);
        @(posedge clock); #1;
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_addr = 17'h00040; cpu_wren = 1'b0;
        @(posedge clock); #1;
        cpu_req = 1'b0;
      end
    join
    n_checks++;
    if (d !== k + 3) begin
      n_fail++; $display("FAIL cap_done: got cycle %0d want 3", d - k);
    end
    n_checks++;
    if (ram[17'h00300] !== 8'h77) begin
      n_fail++; $display("FAIL cap_data: got %h want 77", ram[17'h00300]);
    end
  endtask
`else
  task automatic test_copy_disabled;
    int idx0, k, d;
    logic db;
    idx0 = log_addr.size();
    run_cmd(OP_COPY, 17'h00010, 17'h00700, 17'd3, 8'h00, 10, k, d, db);
    n_checks++;
    if (d !== k || db !== 1'b1) begin
      n_fail++; $display("FAIL nocopy_done: got cycle %0d busy %b want cycle 0 busy 1", d - k, db);
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (log_addr.size() !== idx0) begin
      n_fail++; $display("FAIL nocopy_nowrite: got %0d writes want 0", log_addr.size() - idx0);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_fill();
    test_fill_basic();
    test_contention();
    test_zero_busy();
`ifdef GRPH_BLITTER_COPY_EN
    test_copy_basic();
    test_cap_stall();
`else
    test_copy_disabled();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
